// File: rtl/wb_grf_pkg.sv
// Shared definitions for the writeback stage: writeback source codes and load opcodes.
package wb_grf_pkg;

  localparam logic [2:0] WD_SEL_ALU  = 3'd0;
  localparam logic [2:0] WD_SEL_MEM  = 3'd1;
  localparam logic [2:0] WD_SEL_PC   = 3'd2;
  localparam logic [2:0] WD_SEL_EXT  = 3'd3;
  localparam logic [2:0] WD_SEL_MUDI = 3'd4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  // Codes above MUDI are undefined sources; they never commit.
  function automatic logic sel_valid(input logic [2:0] sel);
    return sel <= WD_SEL_MUDI;
  endfunction

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load data extraction: picks the byte/halfword addressed by the low address bits and extends it.
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] dm_out,
  input  logic [1:0]  off,
  input  logic [5:0]  opcode,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dm_out[7:0];
    case (off)
      2'd0: byte_sel = dm_out[7:0];
      2'd1: byte_sel = dm_out[15:8];
      2'd2: byte_sel = dm_out[23:16];
      2'd3: byte_sel = dm_out[31:24];
      default: byte_sel = dm_out[7:0];
    endcase
    // Halfword loads are aligned upstream, so only off[1] matters.
    half_sel = off[1] ? dm_out[31:16] : dm_out[15:0];
  end

  always_comb begin
    load_val = dm_out;
    case (opcode)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'd0, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'd0, half_sel};
      OP_LW:   load_val = dm_out;
      default: load_val = dm_out;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage and general register file with write-first bypass to the D-stage read ports.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LINK_OFFSET = 8,
  parameter bit TRACE_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A3_W,
  input  logic              WE_W,
  input  logic [2:0]        WD_SEL_W,
  input  logic [DATA_W-1:0] ALU_OUT_W,
  input  logic [DATA_W-1:0] DM_OUT_W,
  input  logic [DATA_W-1:0] EXT_OUT_W,
  input  logic [DATA_W-1:0] MUDI_OUT_W,
  input  logic [DATA_W-1:0] PC_W,
  input  logic [31:0]       INSTR_W,
  input  logic [ADDR_W-1:0] A1_D,
  input  logic [ADDR_W-1:0] A2_D,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic [DATA_W-1:0] WD_W,
  output logic              WE_ACT_W,
  // Pulses for each committed write so a trace can print "@pc: $rd <= data" at the commit edge.
  output logic              trace_vld
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] grf [NREG];
  logic [DATA_W-1:0] load_val;
  logic              unused_instr;

  assign unused_instr = ^INSTR_W[25:0];

  wb_grf_load_ext u_load_ext (
    .dm_out   (DM_OUT_W),
    .off      (ALU_OUT_W[1:0]),
    .opcode   (INSTR_W[31:26]),
    .load_val (load_val)
  );

  always_comb begin
    WD_W = '0;
    case (WD_SEL_W)
      WD_SEL_ALU:  WD_W = ALU_OUT_W;
      WD_SEL_MEM:  WD_W = load_val;
      WD_SEL_PC:   WD_W = PC_W + DATA_W'(LINK_OFFSET);
      WD_SEL_EXT:  WD_W = EXT_OUT_W;
      WD_SEL_MUDI: WD_W = MUDI_OUT_W;
      default:     WD_W = '0;
    endcase
  end

  assign WE_ACT_W  = WE_W && (A3_W != '0) && sel_valid(WD_SEL_W);
  assign trace_vld = TRACE_EN && WE_ACT_W && !rst;

  // Reset wins over a same-edge write; entry 0 is cleared but never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) grf[i] <= '0;
    end else if (WE_ACT_W) begin
      grf[A3_W] <= WD_W;
    end
  end

  always_comb begin
    RD1_D = '0;
    if (A1_D != '0) RD1_D = (WE_ACT_W && A1_D == A3_W) ? WD_W : grf[A1_D];
  end

  always_comb begin
    RD2_D = '0;
    if (A2_D != '0) RD2_D = (WE_ACT_W && A2_D == A3_W) ? WD_W : grf[A2_D];
  end

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: scoreboard queue of expected values, reference model of the GRF.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A3_W, A1_D, A2_D;
  logic        WE_W;
  logic [2:0]  WD_SEL_W;
  logic [31:0] ALU_OUT_W, DM_OUT_W, EXT_OUT_W, MUDI_OUT_W, PC_W, INSTR_W;
  logic [31:0] RD1_D, RD2_D, WD_W;
  logic        WE_ACT_W, trace_vld;

  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;
  int          trace_cnt = 0;
  int          exp_trace = 0;
  logic [5:0]  ops [6];

  wb_grf dut (
    .clk(clk), .rst(rst), .A3_W(A3_W), .WE_W(WE_W), .WD_SEL_W(WD_SEL_W),
    .ALU_OUT_W(ALU_OUT_W), .DM_OUT_W(DM_OUT_W), .EXT_OUT_W(EXT_OUT_W),
    .MUDI_OUT_W(MUDI_OUT_W), .PC_W(PC_W), .INSTR_W(INSTR_W),
    .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .WD_W(WD_W), .WE_ACT_W(WE_ACT_W), .trace_vld(trace_vld)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trace_vld) begin
      $display("@%h: $%0d <= %h", PC_W, A3_W, WD_W);
      trace_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference writeback value, written straight from the source-select and load rules.
  function automatic logic [31:0] ref_wd(input logic [2:0] sel);
    logic [31:0] sh;
    logic [5:0]  op;
    op = INSTR_W[31:26];
    case (sel)
      3'd0: return ALU_OUT_W;
      3'd1: begin
        if (op == 6'h20 || op == 6'h24) begin
          sh = DM_OUT_W >> (8 * ALU_OUT_W[1:0]);
          return (op == 6'h20 && sh[7]) ? (32'hFFFFFF00 | (sh & 32'hFF)) : (sh & 32'hFF);
        end
        if (op == 6'h21 || op == 6'h25) begin
          sh = DM_OUT_W >> (16 * ALU_OUT_W[1]);
          return (op == 6'h21 && sh[15]) ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
        end
        return DM_OUT_W;
      end
      3'd2: return PC_W + 32'd8;
      3'd3: return EXT_OUT_W;
      3'd4: return MUDI_OUT_W;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_commit();
    return WE_W && A3_W != 5'd0 && WD_SEL_W <= 3'd4;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_commit() && a == A3_W) return ref_wd(WD_SEL_W);
    return model[a];
  endfunction

  // Driver tasks
  task automatic drive_idle();
    WE_W = 1'b0; A3_W = '0; WD_SEL_W = '0; A1_D = '0; A2_D = '0;
    ALU_OUT_W = '0; DM_OUT_W = '0; EXT_OUT_W = '0; MUDI_OUT_W = '0; PC_W = '0; INSTR_W = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (exp_commit()) begin
      model[A3_W] = ref_wd(WD_SEL_W);
      exp_trace++;
    end
    @(negedge clk);
  endtask

  task automatic chk_wd(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    #1;
    check(tag, WD_W, exp_q.pop_front());
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1_D = a; A2_D = a;
    exp_q.push_back(exp);
    exp_q.push_back(exp);
    #1;
    check({tag, "_rd1"}, RD1_D, exp_q.pop_front());
    check({tag, "_rd2"}, RD2_D, exp_q.pop_front());
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] sel, input logic [31:0] alu);
    WE_W = 1'b1; A3_W = a; WD_SEL_W = sel; ALU_OUT_W = alu;
    #1;
    tick();
    WE_W = 1'b0;
  endtask

  initial begin
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h0F};
    for (int i = 0; i < 32; i++) model[i] = '0;
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 1: preload, then reset with a concurrent write
    for (int r = 1; r < 32; r++) wr(5'(r), 3'd0, $urandom);
    chk_rd("preload17", 5'd17, model[17]);
    rst = 1'b1;
    WE_W = 1'b1; A3_W = 5'd3; WD_SEL_W = 3'd0; ALU_OUT_W = 32'hAAAA_AAAA;
    tick();
    tick();
    rst = 1'b0;
    drive_idle();
    for (int r = 1; r < 32; r++) chk_rd($sformatf("rst_r%0d", r), 5'(r), 32'd0);

    // 2: write-first bypass, then hold
    WE_W = 1'b1; A3_W = 5'd5; WD_SEL_W = 3'd0; ALU_OUT_W = 32'h1234_5678;
    chk_rd("bypass5", 5'd5, 32'h1234_5678);
    check("we_act5", {31'd0, WE_ACT_W}, 32'd1);
    tick();
    WE_W = 1'b0;
    chk_rd("hold5", 5'd5, 32'h1234_5678);

    // 3: $0 write ignored
    WE_W = 1'b1; A3_W = 5'd0; ALU_OUT_W = 32'hFFFF_FFFF;
    chk_rd("zero_rd", 5'd0, 32'd0);
    check("zero_we_act", {31'd0, WE_ACT_W}, 32'd0);
    check("zero_trace", {31'd0, trace_vld}, 32'd0);
    tick();
    WE_W = 1'b0;

    // 4: load extraction
    WD_SEL_W = 3'd1; DM_OUT_W = 32'h80FF_7F01;
    INSTR_W = {6'h20, 26'd0}; ALU_OUT_W = 32'h3; chk_wd("lb_off3", 32'hFFFF_FF80);
    INSTR_W = {6'h24, 26'd0}; ALU_OUT_W = 32'h3; chk_wd("lbu_off3", 32'h0000_0080);
    INSTR_W = {6'h21, 26'd0}; ALU_OUT_W = 32'h2; chk_wd("lh_off2", 32'hFFFF_80FF);
    INSTR_W = {6'h25, 26'd0}; ALU_OUT_W = 32'h0; chk_wd("lhu_off0", 32'h0000_7F01);
    INSTR_W = {6'h23, 26'd0}; ALU_OUT_W = 32'h0; chk_wd("lw", 32'h80FF_7F01);
    INSTR_W = {6'h20, 26'd0}; ALU_OUT_W = 32'h1; chk_wd("lb_off1", 32'h0000_007F);
    INSTR_W = {6'h0F, 26'd0}; ALU_OUT_W = 32'h3; chk_wd("other_op", 32'h80FF_7F01);
    INSTR_W = {6'h21, 26'd0}; wr(5'd9, 3'd1, 32'h2);
    chk_rd("lh_commit9", 5'd9, 32'hFFFF_80FF);

    // 5: link value and wrap
    PC_W = 32'h0000_3004; wr(5'd31, 3'd2, 32'd0);
    chk_rd("link31", 5'd31, 32'h0000_300C);
    PC_W = 32'hFFFF_FFFC; wr(5'd31, 3'd2, 32'd0);
    chk_rd("link_wrap", 5'd31, 32'h0000_0004);

    // 6: invalid selects suppress the write, then MUDI commits
    EXT_OUT_W = 32'h5555_0000; wr(5'd7, 3'd3, 32'd0);
    chk_rd("ext7", 5'd7, 32'h5555_0000);
    for (int s = 5; s < 8; s++) begin
      WE_W = 1'b1; A3_W = 5'd7; WD_SEL_W = 3'(s);
      chk_wd($sformatf("sel%0d_wd", s), 32'd0);
      check($sformatf("sel%0d_we_act", s), {31'd0, WE_ACT_W}, 32'd0);
      tick();
      WE_W = 1'b0;
      chk_rd($sformatf("sel%0d_keep7", s), 5'd7, 32'h5555_0000);
    end
    MUDI_OUT_W = 32'hDEAD_BEEF; wr(5'd7, 3'd4, 32'd0);
    chk_rd("mudi7", 5'd7, 32'hDEAD_BEEF);

    // Random traffic with scoreboarded WD_W and bypassed reads
    for (int n = 0; n < 60; n++) begin
      WE_W = ($urandom_range(0, 3) != 0);
      A3_W = 5'($urandom_range(0, 31));
      WD_SEL_W = 3'($urandom_range(0, 7));
      ALU_OUT_W = $urandom; DM_OUT_W = $urandom; EXT_OUT_W = $urandom;
      MUDI_OUT_W = $urandom; PC_W = $urandom;
      INSTR_W = {ops[$urandom_range(0, 5)], 26'($urandom)};
      A1_D = A3_W; A2_D = 5'($urandom_range(0, 31));
      exp_q.push_back(ref_wd(WD_SEL_W));
      exp_q.push_back(exp_rd(A1_D));
      exp_q.push_back(exp_rd(A2_D));
      #1;
      check("rnd_wd", WD_W, exp_q.pop_front());
      check("rnd_rd1", RD1_D, exp_q.pop_front());
      check("rnd_rd2", RD2_D, exp_q.pop_front());
      check("rnd_we_act", {31'd0, WE_ACT_W}, {31'd0, exp_commit()});
      tick();
    end
    drive_idle();
    for (int r = 0; r < 32; r++) chk_rd($sformatf("final_r%0d", r), 5'(r), (r == 0) ? 32'd0 : model[r]);

    #1;
    check("trace_cnt", 32'(trace_cnt), 32'(exp_trace));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
